// File: rtl/waveform_monitor_if.sv
// Sample stream and measurement result bundle between a waveform source and its monitor.
interface waveform_monitor_if #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 24
);
    logic              wm_en_i;
    logic              wm_smp_stb_i;
    logic [DATA_W-1:0] wm_smp_i;
    logic [CNT_W-1:0]  wm_period_o;
    logic [DATA_W-1:0] wm_min_o;
    logic [DATA_W-1:0] wm_max_o;
    logic              wm_ovf_o;
    logic              wm_valid_o;
    logic              wm_timeout_o;

    modport master (
        output wm_en_i, wm_smp_stb_i, wm_smp_i,
        input  wm_period_o, wm_min_o, wm_max_o, wm_ovf_o, wm_valid_o, wm_timeout_o
    );
    modport slave (
        input  wm_en_i, wm_smp_stb_i, wm_smp_i,
        output wm_period_o, wm_min_o, wm_max_o, wm_ovf_o, wm_valid_o, wm_timeout_o
    );
endinterface

// File: rtl/waveform_monitor.sv
// Rising mid-scale crossing monitor: period, min/max per period, one result per period.
// Optional WM_TIMEOUT_EN: abort and rearm when the period counter saturates.
module waveform_monitor #(
    parameter int DATA_W = 12,
    parameter int MID    = 2048,
    parameter int HYST   = 16,
    parameter int CNT_W  = 24
) (
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    waveform_monitor_if.slave wm
);
    typedef enum logic [2:0] {IDLE, ARM_LO, ARM_HI, MEAS_LO, MEAS_HI} state_e;

    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [DATA_W-1:0] LO_TH   = DATA_W'(MID - HYST);
    localparam logic [DATA_W-1:0] HI_TH   = DATA_W'(MID + HYST);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_flag_q, ovf_flag_d;
    logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [DATA_W-1:0] min_o_q, min_o_d, max_o_q, max_o_d;
    logic              ovf_q, ovf_d, valid_q, valid_d, timeout_q, timeout_d;
    logic              lo, hi, meas, cnt_sat, tmo_hit;

    always_comb begin
        lo      = wm.wm_smp_stb_i && (wm.wm_smp_i <= LO_TH);
        hi      = wm.wm_smp_stb_i && (wm.wm_smp_i >= HI_TH);
        meas    = (state_q == MEAS_LO) || (state_q == MEAS_HI);
        cnt_sat = (cnt_q == CNT_MAX);
`ifdef WM_TIMEOUT_EN
        tmo_hit = meas && cnt_sat;
`else
        tmo_hit = 1'b0;
`endif
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_flag_d = ovf_flag_q;
        min_d      = min_q;
        max_d      = max_q;
        period_d   = period_q;
        min_o_d    = min_o_q;
        max_o_d    = max_o_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;

        if (meas) begin
            if (cnt_sat) ovf_flag_d = 1'b1;
            else         cnt_d      = cnt_q + 1'b1;
            if (wm.wm_smp_stb_i) begin
                if (wm.wm_smp_i < min_q) min_d = wm.wm_smp_i;
                if (wm.wm_smp_i > max_q) max_d = wm.wm_smp_i;
            end
        end

        // Disable wins over everything: no publish, partial period dropped.
        if (!wm.wm_en_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = ARM_LO;
                ARM_LO:  if (lo) state_d = ARM_HI;
                ARM_HI: begin
                    if (hi) begin
                        state_d    = MEAS_LO;
                        cnt_d      = '0;
                        ovf_flag_d = 1'b0;
                        min_d      = wm.wm_smp_i;
                        max_d      = wm.wm_smp_i;
                    end
                end
                MEAS_LO: begin
                    if (tmo_hit) begin
                        state_d   = ARM_LO;
                        timeout_d = 1'b1;
                    end else if (lo) begin
                        state_d = MEAS_HI;
                    end
                end
                MEAS_HI: begin
                    if (tmo_hit) begin
                        state_d   = ARM_LO;
                        timeout_d = 1'b1;
                    end else if (hi) begin
                        // Crossing sample closes this period and seeds the next one.
                        period_d   = cnt_sat ? CNT_MAX : cnt_q + 1'b1;
                        min_o_d    = min_q;
                        max_o_d    = max_q;
                        ovf_d      = ovf_flag_q || cnt_sat;
                        valid_d    = 1'b1;
                        state_d    = MEAS_LO;
                        cnt_d      = '0;
                        ovf_flag_d = 1'b0;
                        min_d      = wm.wm_smp_i;
                        max_d      = wm.wm_smp_i;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            min_q      <= '0;
            max_q      <= '0;
            period_q   <= '0;
            min_o_q    <= '0;
            max_o_q    <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_flag_q <= ovf_flag_d;
            min_q      <= min_d;
            max_q      <= max_d;
            period_q   <= period_d;
            min_o_q    <= min_o_d;
            max_o_q    <= max_o_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign wm.wm_period_o  = period_q;
    assign wm.wm_min_o     = min_o_q;
    assign wm.wm_max_o     = max_o_q;
    assign wm.wm_ovf_o     = ovf_q;
    assign wm.wm_valid_o   = valid_q;
    assign wm.wm_timeout_o = timeout_q;
endmodule

// File: tb/tb_waveform_monitor.sv
// Scoreboard bench for waveform_monitor (CNT_W=8): timestamp-based crossing model feeds
// expected results into queues; a monitor pops them whenever the DUT pulses valid/timeout.
module tb_waveform_monitor;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam int LO_TH = 2048 - 16;
    localparam int HI_TH = 2048 + 16;

    typedef struct {
        int due;
        int period;
        int mn;
        int mx;
        bit ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    waveform_monitor_if #(.DATA_W(12), .CNT_W(CNT_W)) wif ();
    waveform_monitor #(.DATA_W(12), .MID(2048), .HYST(16), .CNT_W(CNT_W)) dut (
        .sys_clk_i(clk),
        .sys_rst_i(rst_n),
        .wm(wif)
    );

    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;
    exp_t q[$];
    int   tq[$];

    // Reference model state: armed by a low sample, period measured between rising crossings.
    bit m_nonidle = 0;
    bit m_seen_lo = 0;
    int m_t0 = -1;
    int m_min, m_max;

    logic [CNT_W-1:0] h_period = '0;
    logic [11:0]      h_min = '0, h_max = '0;
    logic             h_ovf = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_cnt);
        end
    endtask

    task automatic model(input bit r, input bit en, input bit stb, input int smp);
        int  e, k;
        bit  lo, hi;
        exp_t x;
        e  = edge_cnt + 1;
        lo = stb && (smp <= LO_TH);
        hi = stb && (smp >= HI_TH);
        if (!r) begin
            m_nonidle = 0; m_seen_lo = 0; m_t0 = -1;
            q.delete(); tq.delete();
            return;
        end
        if (!en || !m_nonidle) begin
            m_seen_lo = 0; m_t0 = -1; m_nonidle = en;
            return;
        end
        k = (m_t0 >= 0) ? e - m_t0 : 0;
`ifdef WM_TIMEOUT_EN
        if (m_t0 >= 0 && k - 1 >= MAXC) begin
            tq.push_back(e);
            m_seen_lo = 0; m_t0 = -1;
            return;
        end
`endif
        if (m_seen_lo && hi) begin
            if (m_t0 >= 0) begin
                x.due = e; x.period = (k > MAXC) ? MAXC : k;
                x.mn = m_min; x.mx = m_max; x.ovf = (k > MAXC);
                q.push_back(x);
            end
            m_t0 = e; m_min = smp; m_max = smp; m_seen_lo = 0;
        end else begin
            if (lo) m_seen_lo = 1;
            if (m_t0 >= 0 && stb) begin
                if (smp < m_min) m_min = smp;
                if (smp > m_max) m_max = smp;
            end
        end
    endtask

    task automatic drive(input bit r, input bit en, input bit stb, input int smp);
        logic [11:0] s;
        @(negedge clk);
        s = smp[11:0];
        rst_n = r;
        wif.wm_en_i = en;
        wif.wm_smp_stb_i = stb;
        wif.wm_smp_i = s;
        model(r, en, stb, int'(s));
    endtask

    task automatic level(input int n, input int v, input int spacing, input bit en);
        for (int i = 0; i < n; i++) begin
            drive(1, en, 1, v);
            for (int j = 1; j < spacing; j++) drive(1, en, 0, (j % 2) ? 4095 : 0);
        end
    endtask

    task automatic square(input int reps, input int n, input int spacing);
        for (int r = 0; r < reps; r++) begin
            level(n, 1000, spacing, 1);
            level(n, 3000, spacing, 1);
        end
    endtask

    // Monitor: one sample per clock, 1 time unit after the rising edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        edge_cnt++;
        if (!rst_n) begin
            h_period = '0; h_min = '0; h_max = '0; h_ovf = 1'b0;
            chk("rst_outputs", {wif.wm_valid_o, wif.wm_timeout_o, wif.wm_ovf_o,
                                wif.wm_period_o, wif.wm_min_o, wif.wm_max_o}, 0);
        end else begin
            if (wif.wm_valid_o) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_valid: got valid=1 expected valid=0 (edge %0d)", edge_cnt);
                end else begin
                    x = q.pop_front();
                    chk("valid_latency", edge_cnt, x.due);
                    chk("period", wif.wm_period_o, x.period);
                    chk("min", wif.wm_min_o, x.mn);
                    chk("max", wif.wm_max_o, x.mx);
                    chk("ovf", wif.wm_ovf_o, x.ovf);
                    h_period = x.period[CNT_W-1:0]; h_min = x.mn[11:0];
                    h_max = x.mx[11:0]; h_ovf = x.ovf;
                end
            end else if (q.size() != 0 && q[0].due <= edge_cnt) begin
                tests++; fails++;
                $display("FAIL missing_valid: got valid=0 expected valid=1 (edge %0d)", edge_cnt);
                void'(q.pop_front());
            end
            chk("hold", {wif.wm_period_o, wif.wm_min_o, wif.wm_max_o, wif.wm_ovf_o},
                        {h_period, h_min, h_max, h_ovf});
            if (wif.wm_timeout_o) begin
                if (tq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_timeout: got 1 expected 0 (edge %0d)", edge_cnt);
                end else chk("timeout_edge", edge_cnt, tq.pop_front());
            end else if (tq.size() != 0 && tq[0] <= edge_cnt) begin
                tests++; fails++;
                $display("FAIL missing_timeout: got 0 expected 1 (edge %0d)", edge_cnt);
                void'(tq.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int lv, len, v;
        wif.wm_en_i = 1'b0; wif.wm_smp_stb_i = 1'b0; wif.wm_smp_i = '0;
        // 1: reset with strobes active
        for (int i = 0; i < 3; i++) drive(0, 1, 1, $urandom_range(0, 4095));
        // 2: square, strobe every clock
        square(6, 50, 1);
        // 3: strobe every 4th clock, noise on non-strobed cycles
        square(5, 25, 4);
        // 4: hysteresis band chatter never crosses; then clean 1000/2064 crossings
        for (int i = 0; i < 200; i++) drive(1, 1, 1, (i % 2) ? 2060 : 2040);
        for (int r = 0; r < 3; r++) begin
            level(20, 1000, 1, 1);
            level(20, 2064, 1, 1);
        end
        // 5: disable mid-period, rearm; then reset mid-period
        square(3, 50, 1);
        level(30, 1000, 1, 1);
        level(10, 1000, 1, 0);
        level(20, 1000, 1, 1);
        square(3, 50, 1);
        level(20, 1000, 1, 1);
        drive(0, 1, 1, 1000);
        square(3, 50, 1);
        // 6: stuck high past counter saturation
        level(10, 1000, 1, 1);
        level(10, 3000, 1, 1);
        level(10, 1000, 1, 1);
        level(300, 3000, 1, 1);
        level(10, 1000, 1, 1);
        level(10, 3000, 1, 1);
        level(10, 1000, 1, 1);
        level(10, 3000, 1, 1);
        // 7: random segments, sparse strobes, band noise, occasional disable/reset
        for (int s = 0; s < 120; s++) begin
            lv  = $urandom_range(0, 5);
            len = $urandom_range(1, 120);
            for (int i = 0; i < len; i++) begin
                if (lv < 2)      v = $urandom_range(0, LO_TH);
                else if (lv < 4) v = $urandom_range(HI_TH, 4095);
                else             v = $urandom_range(LO_TH + 1, HI_TH - 1);
                drive(1, 1, ($urandom_range(0, 3) != 0), v);
            end
            if ($urandom_range(0, 29) == 0) level($urandom_range(1, 12), 1000, 1, 0);
            if ($urandom_range(0, 59) == 0) drive(0, 1, 1, 3000);
        end
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0);
        @(negedge clk);
        chk("drain", q.size() + tq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
